alu_sched: RTL and testbench

- Shares one external multi-cycle ALU between two requesters.
- Requester 0 is the calculator key parser. Requester 1 is the music/tone-generation path.
- Captures each request's operands and op, arbitrates round-robin, and issues one operation at a time with a start pulse.
- Waits the op-class latency, then returns result, error and a done strobe to the owning requester.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/req_capture.sv | 55 +++++
 rtl/alu_sched.sv | 177 +++++++++++++++++
 tb/tb_alu_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: op codes, FSM states, latency classes.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'hA;
  localparam logic [3:0] OP_SUB = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  localparam logic [3:0] OP_DIV = 4'hD;
  localparam logic [3:0] OP_MOD = 4'hE;
  localparam logic [3:0] OP_EQ  = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_MUL = 2'd1,
    CLS_DIV = 2'd2,
    CLS_BAD = 2'd3
  } op_class_t;

  // Map an op code to its latency class; anything outside A..E is rejected.
  function automatic op_class_t op_class(input logic [3:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB: cls = CLS_ADD;
      OP_MUL:         cls = CLS_MUL;
      OP_DIV, OP_MOD: cls = CLS_DIV;
      default:        cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/req_capture.sv
// Per-requester front end: rising-edge detect, single pending flag, operand buffer.
module req_capture (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [15:0] src_i,
  input  logic [15:0] dst_i,
  input  logic [3:0]  op_i,
  input  logic        clr_i,
  output logic        pend_o,
  output logic [15:0] src_o,
  output logic [15:0] dst_o,
  output logic [3:0]  op_o
);

  logic        prev_q;
  logic        pend_q, pend_d;
  logic [15:0] src_q, dst_q;
  logic [3:0]  op_q;
  logic        rise;

  assign rise = req_i & ~prev_q;

  // Pending flag: a new edge beats a same-cycle grant clear.
  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d = 1'b0;
    if (rise)  pend_d = 1'b1;
  end

  // Edge history, pending flag and operand buffer (re-edge overwrites the buffer).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
      op_q   <= '0;
    end else begin
      prev_q <= req_i;
      pend_q <= pend_d;
      if (rise) begin
        src_q <= src_i;
        dst_q <= dst_i;
        op_q  <= op_i;
      end
    end
  end

  assign pend_o = pend_q;
  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign op_o   = op_q;

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one multi-cycle ALU between the key parser (0)
// and the tone path (1).
module alu_sched
  import alu_pkg::*;
#(
  parameter int unsigned LAT_ADD = 1,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_DIV = 17,
  parameter int unsigned CW      = 5
) (
  input  logic        IN_clk,
  input  logic        IN_reset,
  input  logic        IN_req0,
  input  logic [15:0] IN_src0,
  input  logic [15:0] IN_dst0,
  input  logic [3:0]  IN_op0,
  input  logic        IN_req1,
  input  logic [15:0] IN_src1,
  input  logic [15:0] IN_dst1,
  input  logic [3:0]  IN_op1,
  input  logic [15:0] IN_alu_result,
  output logic [15:0] OUT_alu_a,
  output logic [15:0] OUT_alu_b,
  output logic [3:0]  OUT_alu_op,
  output logic        OUT_alu_start,
  output logic [15:0] OUT_ans,
  output logic        OUT_err,
  output logic        OUT_done0,
  output logic        OUT_done1,
  output logic        OUT_busy,
  output logic [1:0]  OUT_state
);

  logic        pend0, pend1, clr0, clr1;
  logic [15:0] src0_b, dst0_b, src1_b, dst1_b;
  logic [3:0]  op0_b, op1_b;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] ans_q, ans_d;
  logic        err_q, err_d;
  logic        gnt;
  logic        start_w;
  op_class_t   cls;
  logic [CW-1:0] lat_m1;

  req_capture u_cap0 (
    .clk_i  (IN_clk),
    .rst_ni (IN_reset),
    .req_i  (IN_req0),
    .src_i  (IN_src0),
    .dst_i  (IN_dst0),
    .op_i   (IN_op0),
    .clr_i  (clr0),
    .pend_o (pend0),
    .src_o  (src0_b),
    .dst_o  (dst0_b),
    .op_o   (op0_b)
  );

  req_capture u_cap1 (
    .clk_i  (IN_clk),
    .rst_ni (IN_reset),
    .req_i  (IN_req1),
    .src_i  (IN_src1),
    .dst_i  (IN_dst1),
    .op_i   (IN_op1),
    .clr_i  (clr1),
    .pend_o (pend1),
    .src_o  (src1_b),
    .dst_o  (dst1_b),
    .op_o   (op1_b)
  );

  assign cls    = op_class(op_q);
  assign lat_m1 = (cls == CLS_MUL) ? CW'(LAT_MUL - 1) :
                  (cls == CLS_DIV) ? CW'(LAT_DIV - 1) :
                                     CW'(LAT_ADD - 1);

  // Next-state and datapath update. Operands are copied out of the owner's
  // buffer at grant, so the ALU port already shows them during LAUNCH and a
  // same-cycle re-edge only affects the queued entry, not the launched one.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ans_d   = ans_q;
    err_d   = err_q;
    clr0    = 1'b0;
    clr1    = 1'b0;
    gnt     = 1'b0;
    start_w = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend0 | pend1) begin
          gnt     = (pend0 & pend1) ? rr_q : pend1;
          owner_d = gnt;
          rr_d    = ~gnt;
          clr0    = ~gnt;
          clr1    = gnt;
          a_d     = gnt ? src1_b : src0_b;
          b_d     = gnt ? dst1_b : dst0_b;
          op_d    = gnt ? op1_b  : op0_b;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (cls == CLS_BAD || (cls == CLS_DIV && b_q == '0)) begin
          ans_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          start_w = 1'b1;
          cnt_d   = lat_m1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          ans_d   = IN_alu_result;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, arbitration and result registers; reset aborts any op in flight.
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      ans_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ans_q   <= ans_d;
      err_q   <= err_d;
    end
  end

  assign OUT_alu_a     = a_q;
  assign OUT_alu_b     = b_q;
  assign OUT_alu_op    = op_q;
  assign OUT_alu_start = start_w;
  assign OUT_ans       = ans_q;
  assign OUT_err       = err_q;
  assign OUT_done0     = (state_q == S_DONE) & ~owner_q;
  assign OUT_done1     = (state_q == S_DONE) &  owner_q;
  assign OUT_busy      = (state_q != S_IDLE);
  assign OUT_state     = state_q;

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: expected completions are queued as requests
// are posted and checked when a done strobe appears.
module tb_alu_sched;

  logic        clk = 1'b0;
  logic        IN_reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] src0 = '0, dst0 = '0, src1 = '0, dst1 = '0;
  logic [3:0]  op0 = '0, op1 = '0;
  logic [15:0] alu_result = 16'hDEAD;
  logic [15:0] alu_a, alu_b, ans;
  logic [3:0]  alu_op;
  logic        alu_start, err, done0, done1, busy;
  logic [1:0]  state;

  alu_sched #(.LAT_ADD(1), .LAT_MUL(3), .LAT_DIV(17), .CW(5)) dut (
    .IN_clk        (clk),
    .IN_reset      (IN_reset),
    .IN_req0       (req0),
    .IN_src0       (src0),
    .IN_dst0       (dst0),
    .IN_op0        (op0),
    .IN_req1       (req1),
    .IN_src1       (src1),
    .IN_dst1       (dst1),
    .IN_op1        (op1),
    .IN_alu_result (alu_result),
    .OUT_alu_a     (alu_a),
    .OUT_alu_b     (alu_b),
    .OUT_alu_op    (alu_op),
    .OUT_alu_start (alu_start),
    .OUT_ans       (ans),
    .OUT_err       (err),
    .OUT_done0     (done0),
    .OUT_done1     (done1),
    .OUT_busy      (busy),
    .OUT_state     (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          owner;
    logic [15:0] ans;
    bit          err;
    bit          start;
    int          dcyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n_start = 0;

  // ALU model: returns the true result only in the cycle LAT after start.
  bit          alu_pend = 0;
  int          alu_cyc = 0;
  logic [15:0] alu_res = '0;
  bit          saw_start = 0;

  always @(negedge clk) begin
    if (!IN_reset) begin
      alu_pend   = 0;
      saw_start  = 0;
      alu_result = 16'hDEAD;
    end else begin
      alu_result = (alu_pend && cyc == alu_cyc) ? alu_res : 16'hDEAD;
      if (alu_pend && cyc >= alu_cyc) alu_pend = 0;
      if (alu_start) begin
        n_start++;
        saw_start = 1;
        alu_pend  = 1;
        case (alu_op)
          4'hA: begin alu_res = alu_a + alu_b; alu_cyc = cyc + 1; end
          4'hB: begin alu_res = alu_a - alu_b; alu_cyc = cyc + 1; end
          4'hC: begin alu_res = 16'(alu_a * alu_b); alu_cyc = cyc + 3; end
          4'hD: begin alu_res = (alu_b == 0) ? 16'h0 : alu_a / alu_b; alu_cyc = cyc + 17; end
          4'hE: begin alu_res = (alu_b == 0) ? 16'h0 : alu_a % alu_b; alu_cyc = cyc + 17; end
          default: begin alu_res = 16'h0; alu_cyc = cyc + 1; end
        endcase
      end
      if (done0 || done1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_done: got done0=%b done1=%b ans=%h err=%b cyc=%0d, required no done",
                   done0, done1, ans, err, cyc);
        end else begin
          exp_t e;
          logic [19:0] got, want;
          e    = sb.pop_front();
          got  = {done1, done0, ans, err, saw_start};
          want = {e.owner, ~e.owner, e.ans, e.err, e.start};
          if (got !== want || cyc != e.dcyc) begin
            bad++;
            $display("FAIL sb_done: got {d1,d0,ans,err,start}=%h cyc=%0d, required %h cyc=%0d",
                     got, cyc, want, e.dcyc);
          end
        end
        saw_start = 0;
      end
    end
  end

  // Post request edges (one or both requesters) in one cycle; t = cycle 0.
  task automatic post(input bit e0, input logic [15:0] s0, input logic [15:0] d0, input logic [3:0] o0,
                      input bit e1, input logic [15:0] s1, input logic [15:0] d1, input logic [3:0] o1,
                      output int t);
    @(posedge clk); #1;
    if (e0) begin src0 = s0; dst0 = d0; op0 = o0; req0 = 1'b1; end
    if (e1) begin src1 = s1; dst1 = d1; op1 = o1; req1 = 1'b1; end
    t = cyc;
    @(posedge clk); #1;
    if (e0) req0 = 1'b0;
    if (e1) req1 = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset;
    IN_reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({alu_a, alu_b, alu_op, alu_start, ans, err, done0, done1, busy, state} !== 59'd0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%h b=%h op=%h st=%b ans=%h err=%b d0=%b d1=%b busy=%b state=%0d, required all 0",
               alu_a, alu_b, alu_op, alu_start, ans, err, done0, done1, busy, state);
    end
    @(posedge clk); #3;
    IN_reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_add;
    int t;
    post(1, 16'd12, 16'd30, 4'hA, 0, '0, '0, '0, t);
    sb.push_back('{owner: 1'b0, ans: 16'd42, err: 1'b0, start: 1'b1, dcyc: t + 4});
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({alu_start, alu_a, alu_b, alu_op, state} !== {1'b1, 16'd12, 16'd30, 4'hA, 2'd1}) begin
      bad++;
      $display("FAIL add_launch: got start=%b a=%0d b=%0d op=%h state=%0d cyc=%0d, required 1 12 30 a 1 cyc=%0d",
               alu_start, alu_a, alu_b, alu_op, state, cyc, t + 2);
    end
    drain(60);
    total++;
    if (sb.size() != 0 || ans !== 16'd42 || err !== 1'b0) begin
      bad++;
      $display("FAIL add_hold: got pending=%0d ans=%0d err=%b, required 0 42 0", sb.size(), ans, err);
    end
  endtask

  task automatic test_div_zero;
    int t;
    post(0, '0, '0, '0, 1, 16'd55, 16'd0, 4'hD, t);
    sb.push_back('{owner: 1'b1, ans: 16'd0, err: 1'b1, start: 1'b0, dcyc: t + 3});
    drain(60);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL div0_timeout: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_invalid_op;
    int t;
    logic [3:0] bad_ops [2];
    bad_ops[0] = 4'h5;
    bad_ops[1] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      post(1, 16'd3, 16'd4, bad_ops[i], 0, '0, '0, '0, t);
      sb.push_back('{owner: 1'b0, ans: 16'd0, err: 1'b1, start: 1'b0, dcyc: t + 3});
      drain(60);
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL invalid_op_timeout: got pending=%0d op=%h, required 0", sb.size(), bad_ops[i]);
      end
    end
  endtask

  task automatic test_contention;
    int t;
    // lone requester-1 op makes requester 0 the favoured one for the first pair
    post(0, '0, '0, '0, 1, 16'd1, 16'd2, 4'hA, t);
    sb.push_back('{owner: 1'b1, ans: 16'd3, err: 1'b0, start: 1'b1, dcyc: t + 4});
    drain(60);
    post(1, 16'd3, 16'd5, 4'hC, 1, 16'd6, 16'd7, 4'hC, t);
    sb.push_back('{owner: 1'b0, ans: 16'd15, err: 1'b0, start: 1'b1, dcyc: t + 6});
    sb.push_back('{owner: 1'b1, ans: 16'd42, err: 1'b0, start: 1'b1, dcyc: t + 12});
    drain(80);
    // lone requester-0 op makes requester 1 favoured for the second pair
    post(1, 16'd10, 16'd20, 4'hA, 0, '0, '0, '0, t);
    sb.push_back('{owner: 1'b0, ans: 16'd30, err: 1'b0, start: 1'b1, dcyc: t + 4});
    drain(60);
    post(1, 16'd9, 16'd9, 4'hC, 1, 16'd4, 16'd4, 4'hC, t);
    sb.push_back('{owner: 1'b1, ans: 16'd16, err: 1'b0, start: 1'b1, dcyc: t + 6});
    sb.push_back('{owner: 1'b0, ans: 16'd81, err: 1'b0, start: 1'b1, dcyc: t + 12});
    drain(80);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL contention_timeout: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_back_to_back;
    int t0, t1;
    post(1, 16'd100, 16'd7, 4'hD, 0, '0, '0, '0, t0);
    sb.push_back('{owner: 1'b0, ans: 16'd14, err: 1'b0, start: 1'b1, dcyc: t0 + 20});
    repeat (4) @(posedge clk);
    post(1, 16'd7, 16'd2, 4'hE, 0, '0, '0, '0, t1);
    sb.push_back('{owner: 1'b0, ans: 16'd1, err: 1'b0, start: 1'b1, dcyc: t0 + 40});
    for (int i = 0; i < 80 && cyc != t0 + 22; i++) @(negedge clk);
    total++;
    if ({alu_start, alu_a, alu_b, alu_op} !== {1'b1, 16'd7, 16'd2, 4'hE} || cyc != t0 + 22) begin
      bad++;
      $display("FAIL requeue_launch: got start=%b a=%0d b=%0d op=%h cyc=%0d, required 1 7 2 e cyc=%0d",
               alu_start, alu_a, alu_b, alu_op, cyc, t0 + 22);
    end
    drain(80);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL requeue_timeout: got pending=%0d, required 0", sb.size());
    end
  endtask

  task automatic test_held_request;
    int s0;
    s0 = n_start;
    @(posedge clk); #1;
    src0 = 16'd1; dst0 = 16'd1; op0 = 4'hA; req0 = 1'b1;
    sb.push_back('{owner: 1'b0, ans: 16'd2, err: 1'b0, start: 1'b1, dcyc: cyc + 4});
    repeat (40) @(posedge clk);
    #1 req0 = 1'b0;
    drain(20);
    total++;
    if (n_start - s0 != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL held_request: got starts=%0d pending=%0d, required 1 0", n_start - s0, sb.size());
    end
  endtask

  task automatic test_reset_mid_wait;
    int t, s0;
    post(1, 16'd100, 16'd7, 4'hD, 0, '0, '0, '0, t);
    repeat (9) @(posedge clk);
    #3 IN_reset = 1'b0;
    #1;
    total++;
    if ({alu_a, alu_b, alu_op, alu_start, ans, err, done0, done1, busy, state} !== 59'd0) begin
      bad++;
      $display("FAIL reset_mid_wait: got a=%h b=%h op=%h st=%b ans=%h err=%b d0=%b d1=%b busy=%b state=%0d, required all 0",
               alu_a, alu_b, alu_op, alu_start, ans, err, done0, done1, busy, state);
    end
    repeat (3) @(posedge clk);
    #3 IN_reset = 1'b1;
    s0 = n_start;
    repeat (25) @(posedge clk);
    total++;
    if (n_start != s0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_drop: got starts=%0d busy=%b, required 0 0", n_start - s0, busy);
    end
    post(0, '0, '0, '0, 1, 16'd9, 16'd8, 4'hA, t);
    sb.push_back('{owner: 1'b1, ans: 16'd17, err: 1'b0, start: 1'b1, dcyc: t + 4});
    drain(60);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL post_reset_timeout: got pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_div_zero();
    test_invalid_op();
    test_contention();
    test_back_to_back();
    test_held_request();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
    $fatal(1);
  end

endmodule
